alu_pwr_ctrl: RTL and testbench



---
 rtl/alu_pwr_pkg.sv | 37 +++
 rtl/alu_pwr_timer.sv | 29 ++
 rtl/alu_pwr_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_pwr_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pwr_pkg.sv
// Shared types for the ALU power-sequencing controller: FSM state encoding,
// dwell-counter width and the Moore output decode used by alu_pwr_ctrl.
package alu_pwr_pkg;

   localparam int ALU_PWR_CNT_W = 8;

   typedef enum logic [2:0] {
      OFF     = 3'd0,
      PWR_UP  = 3'd1,
      ON      = 3'd2,
      DRAIN   = 3'd3,
      ISO     = 3'd4,
      PWR_OFF = 3'd5
   } alu_pwr_state_e;

   typedef struct packed {
      logic pwr_en;
      logic iso_en;
      logic ready;
   } alu_pwr_out_t;

   // Power switch, isolation and ready levels that belong to each state.
   function automatic alu_pwr_out_t pwr_decode(alu_pwr_state_e s);
      alu_pwr_out_t o;
      case (s)
         OFF:     o = '{pwr_en: 1'b0, iso_en: 1'b1, ready: 1'b0};
         PWR_UP:  o = '{pwr_en: 1'b1, iso_en: 1'b1, ready: 1'b0};
         ON:      o = '{pwr_en: 1'b1, iso_en: 1'b0, ready: 1'b1};
         DRAIN:   o = '{pwr_en: 1'b1, iso_en: 1'b0, ready: 1'b0};
         ISO:     o = '{pwr_en: 1'b1, iso_en: 1'b1, ready: 1'b0};
         PWR_OFF: o = '{pwr_en: 1'b1, iso_en: 1'b1, ready: 1'b0};
         default: o = '{pwr_en: 1'b0, iso_en: 1'b1, ready: 1'b0};
      endcase
      return o;
   endfunction

endpackage

// File: rtl/alu_pwr_timer.sv
// Loadable down-counter shared by the settle, isolation-setup and drain
// dwell timers. done is high whenever the count sits at zero.
module alu_pwr_timer
   import alu_pwr_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  logic [ALU_PWR_CNT_W-1:0] load_val,
   output logic                     done
);

   logic [ALU_PWR_CNT_W-1:0] cnt;

   // Load on state entry, otherwise count down and park at zero.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - ALU_PWR_CNT_W'(1);
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/alu_pwr_ctrl.sv
// Power-sequencing controller for the gated ALU subsystem. Drives the ALU
// power switch and output isolation so isolation always brackets a power
// transition, and gates start so operations only issue while fully on.
// Optional feature macro: ALU_PWR_CTRL_DRAIN_TIMEOUT_EN (forces DRAIN->ISO
// after DRAIN_MAX busy cycles and raises a sticky drain_err).
module alu_pwr_ctrl
   import alu_pwr_pkg::*;
#(
   parameter int PWR_SETTLE = 4,
   parameter int ISO_SETUP  = 2,
   parameter int DRAIN_MAX  = 64
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       pwr_req,
   input  logic       alu_busy,
   input  logic       start_in,
   output logic       start_out,
   output logic       alu_pwr_en,
   output logic       iso_en,
   output logic       alu_ready,
   output logic [2:0] pwr_state
`ifdef ALU_PWR_CTRL_DRAIN_TIMEOUT_EN
   ,
   output logic       drain_err
`endif
);

   if (PWR_SETTLE < 1 || PWR_SETTLE > 255 || ISO_SETUP < 1 || ISO_SETUP > 255 ||
       DRAIN_MAX < 1 || DRAIN_MAX > 255) begin : g_bad_params
      $error("alu_pwr_ctrl: PWR_SETTLE, ISO_SETUP and DRAIN_MAX must be 1..255");
   end

   // The timer exits when it reaches zero, so a dwell of N loads N-1.
   localparam logic [ALU_PWR_CNT_W-1:0] SETTLE_LD = ALU_PWR_CNT_W'(PWR_SETTLE - 1);
   localparam logic [ALU_PWR_CNT_W-1:0] ISO_LD    = ALU_PWR_CNT_W'(ISO_SETUP - 1);
`ifdef ALU_PWR_CTRL_DRAIN_TIMEOUT_EN
   localparam logic [ALU_PWR_CNT_W-1:0] DRAIN_LD  = ALU_PWR_CNT_W'(DRAIN_MAX - 1);
`endif

   alu_pwr_state_e           state;
   alu_pwr_out_t             outs;
   logic                     go_up;
   logic                     go_drain;
   logic                     drain_exit;
   logic                     drain_timeout;
   logic                     go_iso;
   logic                     tmr_load;
   logic [ALU_PWR_CNT_W-1:0] tmr_load_val;
   logic                     tmr_done;

   // Transition requests and dwell-timer load control.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      go_up         = 1'b0;
      go_drain      = 1'b0;
      drain_exit    = 1'b0;
      drain_timeout = 1'b0;
      tmr_load      = 1'b0;
      tmr_load_val  = '0;

      go_up      = (state == OFF) && pwr_req;
      go_drain   = (state == ON) && !pwr_req;
      drain_exit = (state == DRAIN) && !pwr_req && !alu_busy;
`ifdef ALU_PWR_CTRL_DRAIN_TIMEOUT_EN
      drain_timeout = (state == DRAIN) && !pwr_req && alu_busy && tmr_done;
`endif
      go_iso = drain_exit || drain_timeout;

      if (go_up) begin
         tmr_load     = 1'b1;
         tmr_load_val = SETTLE_LD;
      end else if (go_iso) begin
         tmr_load     = 1'b1;
         tmr_load_val = ISO_LD;
      end
`ifdef ALU_PWR_CTRL_DRAIN_TIMEOUT_EN
      else if (go_drain) begin
         tmr_load     = 1'b1;
         tmr_load_val = DRAIN_LD;
      end
`endif
   end

   alu_pwr_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .done     (tmr_done)
   );

   // Sequencing FSM; outputs are registered alongside the state they decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= OFF;
         outs  <= pwr_decode(OFF);
      end else begin
         case (state)
            OFF: if (go_up) begin
               state <= PWR_UP;
               outs  <= pwr_decode(PWR_UP);
            end
            PWR_UP: if (tmr_done) begin
               state <= ON;
               outs  <= pwr_decode(ON);
            end
            ON: if (go_drain) begin
               state <= DRAIN;
               outs  <= pwr_decode(DRAIN);
            end
            DRAIN: if (pwr_req) begin
               state <= ON;
               outs  <= pwr_decode(ON);
            end else if (go_iso) begin
               state <= ISO;
               outs  <= pwr_decode(ISO);
            end
            ISO: if (tmr_done) begin
               state <= PWR_OFF;
               outs  <= pwr_decode(PWR_OFF);
            end
            PWR_OFF: begin
               state <= OFF;
               outs  <= pwr_decode(OFF);
            end
            default: begin
               state <= OFF;
               outs  <= pwr_decode(OFF);
            end
         endcase
      end
   end

`ifdef ALU_PWR_CTRL_DRAIN_TIMEOUT_EN
   // Sticky record that a drain was cut short by the timeout.
   always_ff @(posedge clk) begin
      if (rst)
         drain_err <= 1'b0;
      else if (drain_timeout)
         drain_err <= 1'b1;
   end
`endif

   assign alu_pwr_en = outs.pwr_en;
   assign iso_en     = outs.iso_en;
   assign alu_ready  = outs.ready;
   assign pwr_state  = state;
   // A start issued in the cycle pwr_req drops is discarded.
   assign start_out  = start_in && (state == ON) && pwr_req;

endmodule

// File: tb/tb_alu_pwr_ctrl.sv
// Self-checking bench for alu_pwr_ctrl: a cycle-level model of the power
// sequencing rules checked every cycle, plus directed hand-computed checks.
module tb_alu_pwr_ctrl;
   import alu_pwr_pkg::*;

   localparam int PWR_SETTLE = 4;
   localparam int ISO_SETUP  = 2;
   localparam int DRAIN_MAX  = 8;
`ifdef ALU_PWR_CTRL_DRAIN_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pwr_req = 1'b0;
   logic       alu_busy = 1'b0;
   logic       start_in = 1'b0;
   logic       start_out;
   logic       alu_pwr_en;
   logic       iso_en;
   logic       alu_ready;
   logic [2:0] pwr_state;
`ifdef ALU_PWR_CTRL_DRAIN_TIMEOUT_EN
   logic       drain_err;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   alu_pwr_ctrl #(
      .PWR_SETTLE (PWR_SETTLE),
      .ISO_SETUP  (ISO_SETUP),
      .DRAIN_MAX  (DRAIN_MAX)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pwr_req    (pwr_req),
      .alu_busy   (alu_busy),
      .start_in   (start_in),
      .start_out  (start_out),
      .alu_pwr_en (alu_pwr_en),
      .iso_en     (iso_en),
      .alu_ready  (alu_ready),
      .pwr_state  (pwr_state)
`ifdef ALU_PWR_CTRL_DRAIN_TIMEOUT_EN
      ,
      .drain_err  (drain_err)
`endif
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   // Tracks which phase the sequence is in and how many cycles it has spent
   // there (1 = first cycle after entry).
   alu_pwr_state_e m_state = OFF;
   int             m_dwell = 0;
   bit             m_err   = 1'b0;
   bit             m_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_state <= OFF;
         m_dwell <= 0;
         m_err   <= 1'b0;
         m_valid <= 1'b1;
      end else begin
         case (m_state)
            OFF: if (pwr_req) begin m_state <= PWR_UP; m_dwell <= 1; end
            PWR_UP: if (m_dwell == PWR_SETTLE) m_state <= ON;
                    else m_dwell <= m_dwell + 1;
            ON: if (!pwr_req) begin m_state <= DRAIN; m_dwell <= 1; end
            DRAIN: begin
               if (pwr_req) m_state <= ON;
               else if (!alu_busy) begin m_state <= ISO; m_dwell <= 1; end
               else if (TIMEOUT_EN && m_dwell == DRAIN_MAX) begin
                  m_state <= ISO; m_dwell <= 1; m_err <= 1'b1;
               end else m_dwell <= m_dwell + 1;
            end
            ISO: if (m_dwell == ISO_SETUP) m_state <= PWR_OFF;
                 else m_dwell <= m_dwell + 1;
            default: m_state <= OFF;
         endcase
      end
   end

   // Compare every cycle on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         check("cyc_state", pwr_state, m_state);
         check("cyc_pwr_en", alu_pwr_en, m_state != OFF);
         check("cyc_iso_en", iso_en, !(m_state == ON || m_state == DRAIN));
         check("cyc_ready", alu_ready, m_state == ON);
         check("cyc_start_out", start_out, start_in && pwr_req && m_state == ON);
         check("cyc_iso_legal", !(alu_pwr_en === 1'b0 && iso_en === 1'b0), 1'b1);
`ifdef ALU_PWR_CTRL_DRAIN_TIMEOUT_EN
         check("cyc_drain_err", drain_err, m_err);
`endif
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      // Reset and idle.
      repeat (2) tick();
      check("rst_pwr_en", alu_pwr_en, 1'b0);
      check("rst_iso_en", iso_en, 1'b1);
      check("rst_ready", alu_ready, 1'b0);
      check("rst_start_out", start_out, 1'b0);
      check("rst_state", pwr_state, 3'd0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_pwr_en", alu_pwr_en, 1'b0);
         check("idle_iso_en", iso_en, 1'b1);
         check("idle_state", pwr_state, 3'd0);
      end

      // Power-up: request sampled at edge 0.
      pwr_req = 1'b1;
      tick();                                   // edge 0
      check("up_e0_pwr_en", alu_pwr_en, 1'b1);
      check("up_e0_iso_en", iso_en, 1'b1);
      start_in = 1'b1; #1;
      check("up_start_blocked", start_out, 1'b0);
      start_in = 1'b0;
      repeat (3) tick();                        // edge 3
      check("up_e3_iso_en", iso_en, 1'b1);
      check("up_e3_ready", alu_ready, 1'b0);
      tick();                                   // edge 4
      check("up_e4_iso_en", iso_en, 1'b0);
      check("up_e4_ready", alu_ready, 1'b1);
      start_in = 1'b1; #1;
      check("on_start_pass", start_out, 1'b1);
      start_in = 1'b0;
      repeat (5) tick();                        // edge 9

      // Power-down with drain: pwr_req low at edge 10, busy through 12.
      pwr_req = 1'b0; alu_busy = 1'b1; start_in = 1'b1; #1;
      check("start_dropped", start_out, 1'b0);
      tick();                                   // edge 10
      start_in = 1'b0;
      check("dn_e10_state", pwr_state, DRAIN);
      check("dn_e10_iso_en", iso_en, 1'b0);
      check("dn_e10_ready", alu_ready, 1'b0);
      repeat (2) tick();                        // edge 12
      check("dn_e12_iso_en", iso_en, 1'b0);
      alu_busy = 1'b0;
      tick();                                   // edge 13
      check("dn_e13_iso_en", iso_en, 1'b1);
      check("dn_e13_pwr_en", alu_pwr_en, 1'b1);
      repeat (2) tick();                        // edge 15
      check("dn_e15_pwr_en", alu_pwr_en, 1'b1);
      tick();                                   // edge 16
      check("dn_e16_pwr_en", alu_pwr_en, 1'b0);
      check("dn_e16_state", pwr_state, 3'd0);

      // Drain abort: request returns while busy.
      pwr_req = 1'b1;
      repeat (5) tick();
      check("ab_on_ready", alu_ready, 1'b1);
      pwr_req = 1'b0; alu_busy = 1'b1;
      tick();
      check("ab_drain_state", pwr_state, DRAIN);
      tick();
      pwr_req = 1'b1;
      tick();
      check("ab_back_state", pwr_state, ON);
      check("ab_back_ready", alu_ready, 1'b1);
      check("ab_back_iso_en", iso_en, 1'b0);
      alu_busy = 1'b0;

      // Reset in the 2nd PWR_UP cycle, then a full re-settle.
      pwr_req = 1'b0;
      repeat (5) tick();
      check("rs_off_state", pwr_state, 3'd0);
      pwr_req = 1'b1;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      check("rs_pwr_en", alu_pwr_en, 1'b0);
      check("rs_iso_en", iso_en, 1'b1);
      check("rs_state", pwr_state, 3'd0);
      rst = 1'b0;
      tick();                                   // new edge 0
      repeat (3) tick();                        // new edge 3
      check("rs_e3_iso_en", iso_en, 1'b1);
      check("rs_e3_ready", alu_ready, 1'b0);
      tick();                                   // new edge 4
      check("rs_e4_ready", alu_ready, 1'b1);

      // ALU busy stuck high during drain.
      pwr_req = 1'b0; alu_busy = 1'b1;
      tick();                                   // DRAIN entry
`ifdef ALU_PWR_CTRL_DRAIN_TIMEOUT_EN
      repeat (7) tick();
      check("to_e7_state", pwr_state, DRAIN);
      check("to_e7_err", drain_err, 1'b0);
      tick();
      check("to_e8_state", pwr_state, ISO);
      check("to_e8_err", drain_err, 1'b1);
      check("to_e8_iso_en", iso_en, 1'b1);
      repeat (3) tick();
      check("to_off_state", pwr_state, 3'd0);
      check("to_held_err", drain_err, 1'b1);
      alu_busy = 1'b0;
      rst = 1'b1;
      tick();
      check("to_rst_err", drain_err, 1'b0);
      rst = 1'b0;
`else
      repeat (20) tick();
      check("wait_drain_state", pwr_state, DRAIN);
      check("wait_drain_pwr_en", alu_pwr_en, 1'b1);
      alu_busy = 1'b0;
      tick();
      check("wait_iso_state", pwr_state, ISO);
      repeat (3) tick();
      check("wait_off_state", pwr_state, 3'd0);
`endif

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
